// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// The master side issues operations and HI/LO writes; the slave side computes.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] W_Data;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    output hi_we, lo_we, W_Data,
    input  busy, done, div_zero,
    input  HI, LO
  );

  modport slave (
    input  start, op, A, B,
    input  hi_we, lo_we, W_Data,
    output busy, done, div_zero,
    output HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide with HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on magnitudes.
module mul_div_unit (
  input  logic             clk,
  input  logic             rst,
  mul_div_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t      state;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        last;
  logic [4:0]  cnt;
  logic [31:0] opnd;
  logic [63:0] acc;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy_r;
  logic        done_r;
  logic        dz_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_up;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] div_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    a_mag = (bus.op[0] && bus.A[31]) ? -bus.A : bus.A;
    b_mag = (bus.op[0] && bus.B[31]) ? -bus.B : bus.B;
    mul_sum = {1'b0, acc[63:32]} + {1'b0, opnd};
    mul_nxt = acc[0] ? {mul_sum, acc[31:1]}
                     : {1'b0, acc[63:1]};
    // partial remainder can reach 33 bits after the shift
    div_up  = acc[63:31];
    div_ge  = div_up >= {1'b0, opnd};
    div_sub = div_up[31:0] - opnd;
    div_nxt = div_ge ? {div_sub, acc[30:0], 1'b1}
                     : {acc[62:0], 1'b0};
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[31:0] : acc[31:0];
    rem  = neg_r ? -acc[63:32] : acc[63:32];
    res_hi = is_div ? rem : prod[63:32];
    res_lo = is_div ? quo : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      last   <= 1'b0;
      cnt    <= 5'd0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi <= bus.W_Data;
          if (bus.lo_we) lo <= bus.W_Data;
          if (bus.start) begin
            if (bus.op[1] && bus.B == 32'd0) begin
              dz_r   <= 1'b1;
              done_r <= 1'b1;
            end else begin
              dz_r   <= 1'b0;
              state  <= RUN;
              busy_r <= 1'b1;
              is_div <= bus.op[1];
              neg_q  <= bus.op[0] & (bus.A[31] ^ bus.B[31]);
              neg_r  <= bus.op[0] & bus.A[31];
              cnt    <= 5'd0;
              last   <= 1'b0;
              opnd   <= bus.op[1] ? b_mag : a_mag;
              acc    <= {32'd0, bus.op[1] ? a_mag : b_mag};
            end
          end
        end
        RUN: begin
          if (last) begin
            state <= FIN;
            last  <= 1'b0;
          end else begin
            acc  <= is_div ? div_nxt : mul_nxt;
            cnt  <= cnt + 5'd1;
            last <= (cnt == 5'd31);
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          hi     <= res_hi;
          lo     <= res_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.HI       = hi;
  assign bus.LO       = lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit.
// Table of operations plus hand sequences for abort, ignore and div-by-zero.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    bus.start  = 1'b0;
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b0;
  endtask

  // Issue one op; return cycles from accept edge to done and busy-low count.
  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int e,
                        output int busy_lo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    e = 0;
    busy_lo = 0;
    while (!bus.done && e < 40) begin
      if (!bus.busy) busy_lo++;
      @(posedge clk);
      e++;
      @(negedge clk);
    end
  endtask

  initial begin
    int e;
    int blo;
    int dones;
    int exp_e;
    n_chk  = 0;
    n_fail = 0;
    idle_bus();
    bus.op     = 2'b00;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.W_Data = 32'd0;

    vt[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vt[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vt[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[4]  = '{2'b10, 32'h0000000A, 32'h00000003, 32'h00000001, 32'h00000003, 1'b0};
    vt[5]  = '{2'b01, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vt[6]  = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vt[7]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[8]  = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vt[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[10] = '{2'b11, 32'h00000005, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);

    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, e, blo);
      exp_e = vt[i].dz ? 0 : 34;
      chk($sformatf("v%0d_lat", i), e, exp_e);
      chk($sformatf("v%0d_busy_gap", i), blo, 0);
      chk($sformatf("v%0d_hi", i), bus.HI, vt[i].hi);
      chk($sformatf("v%0d_lo", i), bus.LO, vt[i].lo);
      chk($sformatf("v%0d_dz", i), bus.div_zero, vt[i].dz);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
    end

    // mthi/mtlo, then divide by zero leaves them intact
    @(negedge clk);
    bus.hi_we  = 1'b1;
    bus.W_Data = 32'h12345678;
    @(negedge clk);
    bus.hi_we  = 1'b0;
    bus.lo_we  = 1'b1;
    bus.W_Data = 32'h9ABCDEF0;
    @(negedge clk);
    bus.lo_we  = 1'b0;
    chk("mthi", bus.HI, 32'h12345678);
    chk("mtlo", bus.LO, 32'h9ABCDEF0);
    run_op(2'b10, 32'd10, 32'd0, e, blo);
    chk("dz_lat", e, 0);
    chk("dz_flag", bus.div_zero, 1);
    chk("dz_busy", bus.busy, 0);
    chk("dz_hi", bus.HI, 32'h12345678);
    chk("dz_lo", bus.LO, 32'h9ABCDEF0);
    run_op(2'b10, 32'd10, 32'd3, e, blo);
    chk("dz_clr_flag", bus.div_zero, 0);
    chk("dz_clr_lo", bus.LO, 3);
    chk("dz_clr_hi", bus.HI, 1);

    // both strobes together in IDLE
    @(negedge clk);
    bus.hi_we  = 1'b1;
    bus.lo_we  = 1'b1;
    bus.W_Data = 32'hA5A5A5A5;
    @(negedge clk);
    idle_bus();
    chk("both_hi", bus.HI, 32'hA5A5A5A5);
    chk("both_lo", bus.LO, 32'hA5A5A5A5);

    // second start during busy ignored; mthi during busy dropped
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.A     = 32'hFFFFFFFD;
    bus.B     = 32'h00000005;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    e = 0;
    dones = 0;
    while (e < 80) begin
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          chk("ign_lat", e, 34);
          chk("ign_hi", bus.HI, 32'hFFFFFFFF);
          chk("ign_lo", bus.LO, 32'hFFFFFFF1);
        end
      end
      if (e == 4) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.A     = 32'd2;
        bus.B     = 32'd2;
      end else if (e == 10) begin
        bus.start  = 1'b0;
        bus.hi_we  = 1'b1;
        bus.W_Data = 32'hDEADBEEF;
      end else begin
        idle_bus();
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    chk("ign_done_count", dones, 1);
    chk("ign_hi_kept", bus.HI, 32'hFFFFFFFF);

    // reset mid-run aborts; start/mthi during reset ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.A     = 32'd7;
    bus.B     = 32'd6;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    e = 0;
    dones = 0;
    while (e < 60) begin
      if (bus.done) dones++;
      if (e == 9) begin
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.hi_we  = 1'b1;
        bus.W_Data = 32'h55555555;
      end else begin
        rst = 1'b0;
        idle_bus();
      end
      @(posedge clk);
      e++;
      @(negedge clk);
      if (e == 10) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.HI, 0);
        chk("abort_lo", bus.LO, 0);
      end
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle", bus.busy, 0);
    chk("abort_hi_end", bus.HI, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state changes on its rising edge) and rst input 1 (synchronous, active-high).
REQ-002 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-003 op  input  2  operation select, captured with start: 00 multu, 01 mult, 10 divu, 11 div.
REQ-004 A  input  32  multiplicand / dividend (rs data), captured with start.
REQ-005 B  input  32  multiplier / divisor (rt data), captured with start.
REQ-006 hi_we  input  1  mthi write strobe.
REQ-007 lo_we  input  1  mtlo write strobe.
REQ-008 W_Data  input  32  mthi/mtlo write data.
REQ-009 busy  output  1  operation in progress.
REQ-010 done  output  1  one-cycle pulse; HI/LO hold the new result while it is high.
REQ-011 div_zero  output  1  sticky flag; last accepted divide had B==0.
REQ-012 HI  output  32  HI register: product[63:32] or remainder.
REQ-013 LO  output  32  LO register: product[31:0] or quotient.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-015 IDLE with start=1 at edge k SHALL capture op, A and B, convert signed operands (op[0]=1) to magnitudes, clear the 5-bit iteration counter, and enter RUN; busy=1 from edge k+1.
REQ-016 RUN SHALL perform one iteration per cycle for exactly 32 cycles, then enter FIN at edge k+33.
- multiply: shift-add over a 64-bit accumulator.
- divide: restoring shift-subtract over a 64-bit remainder/quotient pair.
REQ-017 At the edge leaving FIN (k+34), HI/LO SHALL load the sign-corrected result and the FSM SHALL return to IDLE; busy=0 and done=1 for exactly one cycle after that edge.
REQ-018 Sign correction SHALL be applied as follows:
- mult: product negated when A[31]^B[31].
- div: quotient negated when A[31]^B[31]; remainder takes the sign of A.
- unsigned ops: no correction.
REQ-019 div 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0 with no trap.
REQ-020 A divide (op[1]=1) with B==0 accepted at edge k SHALL:
- skip RUN/FIN and stay IDLE;
- leave HI/LO unchanged;
- set div_zero=1;
- pulse done in the cycle after edge k; busy stays 0.
REQ-021 Any accepted operation with a nonzero divisor, and any multiply, SHALL clear div_zero at the accepting edge.
REQ-022 start SHALL be ignored while busy=1, with no queuing.
REQ-023 In IDLE, hi_we/lo_we SHALL write W_Data into HI/LO at the edge.
- Both strobes may be asserted together.
- A write coinciding with an accepted start is applied; the later result overwrites it.
REQ-024 hi_we/lo_we SHALL be ignored while busy=1.
REQ-025 HI and LO SHALL change only through REQ-017, REQ-023 or reset.
REQ-026 done SHALL never be asserted while busy=1.

Reset
REQ-027 rst=1 at an edge SHALL force, at that edge and in any state:
- state IDLE;
- HI=0, LO=0, busy=0, done=0, div_zero=0;
- counter and accumulators to 0.
REQ-028 A reset during RUN or FIN SHALL abort the operation, with no done pulse and no HI/LO update.
REQ-029 start, hi_we and lo_we SHALL be ignored in any cycle with rst=1.

Verification
REQ-030 multu A=0xFFFFFFFF B=0xFFFFFFFF, start at edge k -> busy on k+1..k+34, done at k+34, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 mult A=0xFFFFFFFD (-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; a second start pulse at k+5 is ignored, and done occurs once at k+34.
REQ-032 div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 After mthi 0x12345678 and mtlo 0x9ABCDEF0, divu A=10 B=0 -> done after k+1, div_zero=1, HI/LO unchanged; a following divu 10/3 -> div_zero=0, LO=3, HI=1.
REQ-034 start multu 7*6, then rst at k+10 -> from k+10: busy=0, HI=LO=0, no done pulse at k+34; mthi while busy is dropped.
